// File: rtl/memory_access_sequencer.sv
// rtl/memory_access_sequencer.sv - load/store sequencer with misaligned split and lane alignment
module memory_access_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ1, S_REQ2, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] low_q, low_d;
  logic [XLEN-1:0] load_data_q, load_data_d;

  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic [2*XLEN-1:0] lane_data;
  logic              split;
  logic [XLEN-1:0]   word_addr;

  function automatic logic legal_f3(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
      default:                                legal_f3 = 1'b0;
    endcase
  endfunction

  // Shift the {high, low} word pair down to the access offset, then extend to n bytes.
  function automatic logic [XLEN-1:0] extend(input logic [2*XLEN-1:0] pair,
                                             input logic [1:0] o, input logic [2:0] f3);
    logic [XLEN-1:0] s;
    s = XLEN'(pair >> {o, 3'b000});
    case (f3)
      3'b000:  extend = {{24{s[7]}}, s[7:0]};
      3'b001:  extend = {{16{s[15]}}, s[15:0]};
      3'b100:  extend = {24'd0, s[7:0]};
      3'b101:  extend = {16'd0, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  // Lane geometry of the latched access; the upper half of each shift belongs to the second word.
  always_comb begin
    off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, size_mask} << off;
    lane_data = {{XLEN{1'b0}}, sdata_q} << {off, 3'b000};
    split     = |lane_mask[7:4];
    word_addr = {addr_q[XLEN-1:2], 2'b00};
  end

  // Next-state, datapath capture and bus/handshake outputs.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    low_d       = low_q;
    load_data_d = load_data_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wmask   = 4'b0000;
    mem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        busy = start;
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = address;
          sdata_d    = store_data;
          if (legal_f3(funct3)) begin
            state_d = S_REQ1;
          end else begin
            state_d     = S_DONE;
            load_data_d = '0;
          end
        end
      end
      S_REQ1: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = word_addr;
        mem_wmask = is_store_q ? lane_mask[3:0] : 4'b0000;
        mem_wdata = lane_data[XLEN-1:0];
        if (mem_ack) begin
          low_d = mem_rdata;
          if (split) begin
            state_d = S_REQ2;
          end else begin
            state_d = S_DONE;
            if (!is_store_q) load_data_d = extend({{XLEN{1'b0}}, mem_rdata}, off, funct3_q);
          end
        end
      end
      S_REQ2: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = word_addr + XLEN'(4);
        mem_wmask = is_store_q ? lane_mask[7:4] : 4'b0000;
        mem_wdata = lane_data[2*XLEN-1:XLEN];
        if (mem_ack) begin
          state_d = S_DONE;
          if (!is_store_q) load_data_d = extend({mem_rdata, low_q}, off, funct3_q);
        end
      end
      default: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_data = load_data_q;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      sdata_q     <= '0;
      low_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      low_q       <= low_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb/tb_memory_access_sequencer.sv - directed self-checking bench for memory_access_sequencer
module tb_memory_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  memory_access_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .address(address), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access from start to done; inputs are scrambled after start to prove they were latched.
  task automatic do_access(input string name, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rd0, input logic [31:0] rd1, input int waits,
                           input int nreq, input logic [31:0] a1, input logic [3:0] m1,
                           input logic [31:0] w1, input logic [31:0] a2, input logic [3:0] m2,
                           input logic [31:0] w2, input int exp_done, input logic [31:0] exp_load);
    int cyc;
    int reqi;
    int waited;
    bit got_done;
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; address = addr; store_data = sdata;
    @(negedge clk);
    check({name, "/busy_c0"}, 32'(busy), 32'd1);
    check({name, "/req_c0"}, 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; is_store = ~st; funct3 = 3'b111; address = 32'hA5A5A5A5; store_data = ~sdata;
    cyc = 1; reqi = 0; waited = 0; got_done = 0;
    while (cyc < 20 && !got_done) begin
      @(negedge clk);
      if (mem_req) begin
        if (reqi >= nreq) begin
          check({name, "/extra_req"}, 32'(reqi + 1), 32'(nreq));
        end else begin
          check($sformatf("%s/addr%0d", name, reqi), mem_addr, (reqi == 0) ? a1 : a2);
          check($sformatf("%s/mask%0d", name, reqi), 32'(mem_wmask), 32'((reqi == 0) ? m1 : m2));
          check($sformatf("%s/we%0d", name, reqi), 32'(mem_we), 32'(st));
          if (st) check($sformatf("%s/wdata%0d", name, reqi), mem_wdata, (reqi == 0) ? w1 : w2);
        end
        if (waited < waits) begin
          mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0; waited++;
        end else begin
          mem_ack = 1'b1; mem_rdata = (reqi == 0) ? rd0 : rd1; waited = 0; reqi++;
        end
      end else if (done) begin
        check({name, "/done_cycle"}, 32'(cyc), 32'(exp_done));
        check({name, "/load_data"}, load_data, exp_load);
        check({name, "/nreq"}, 32'(reqi), 32'(nreq));
        check({name, "/busy_done"}, 32'(busy), 32'd0);
        check({name, "/addr_done"}, mem_addr, 32'd0);
        got_done = 1;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      cyc++;
    end
    if (!got_done) check({name, "/timeout"}, 32'(cyc), 32'(exp_done));
    @(negedge clk);
    check({name, "/done_pulse"}, 32'(done), 32'd0);
    check({name, "/load_held"}, load_data, exp_load);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    address = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/req", 32'(mem_req), 32'd0);
    check("rst/we", 32'(mem_we), 32'd0);
    check("rst/addr", mem_addr, 32'd0);
    check("rst/mask", 32'(mem_wmask), 32'd0);
    check("rst/wdata", mem_wdata, 32'd0);
    check("rst/load", load_data, 32'd0);
    reset = 1'b0;

    do_access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0,
              1, 32'h100, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 2, 32'hDEADBEEF);
    do_access("sh_split", 1'b1, 3'b001, 32'h203, 32'h0000ABCD, 32'h0, 32'h0, 0,
              2, 32'h200, 4'b1000, 32'hCD000000, 32'h204, 4'b0001, 32'h000000AB, 3, 32'hDEADBEEF);
    do_access("lh_split", 1'b0, 3'b001, 32'h003, 32'h0, 32'h80AABBCC, 32'h000000FF, 0,
              2, 32'h000, 4'b0000, 32'h0, 32'h004, 4'b0000, 32'h0, 3, 32'hFFFFFF80);
    do_access("lhu_split", 1'b0, 3'b101, 32'h003, 32'h0, 32'h80AABBCC, 32'h000000FF, 0,
              2, 32'h000, 4'b0000, 32'h0, 32'h004, 4'b0000, 32'h0, 3, 32'h0000FF80);
    do_access("lb_wait", 1'b0, 3'b000, 32'h102, 32'h0, 32'h00850000, 32'h0, 3,
              1, 32'h100, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 5, 32'hFFFFFF85);
    do_access("lbu_wait", 1'b0, 3'b100, 32'h102, 32'h0, 32'h00850000, 32'h0, 3,
              1, 32'h100, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 5, 32'h00000085);
    do_access("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h12345678, 32'h0, 32'h0, 1,
              2, 32'hFFFFFFFC, 4'b1100, 32'h56780000, 32'h0, 4'b0011, 32'h00001234, 5, 32'h00000085);
    do_access("lw2", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0,
              1, 32'h100, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 2, 32'hDEADBEEF);

    // Reset during REQ2 of a split LW at 0x002.
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h002;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("mid/req1", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("mid/req2_addr", mem_addr, 32'h004);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid/req", 32'(mem_req), 32'd0);
    check("mid/busy", 32'(busy), 32'd0);
    check("mid/done", 32'(done), 32'd0);
    check("mid/load", load_data, 32'd0);
    @(negedge clk);
    check("mid/no_done", 32'(done), 32'd0);

    do_access("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0,
              1, 32'h100, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 2, 32'hDEADBEEF);
    do_access("illegal", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0,
              0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
